// File: rtl/uart_burst_tx.sv
// Burst UART transmitter: on a trigger it sends MSG_LEN bytes back-to-back as 8N1/8N2 frames.
// Define UART_BURST_PARITY_EN to insert an even-parity bit after the data bits of each frame.
module uart_burst_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int MSG_LEN    = 4,
  parameter int PERIOD_CYC = 100_000_000,
  parameter int STOP_BITS  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic                     auto_en,
  input  logic [8*MSG_LEN-1:0]     msg,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(MSG_LEN):0] byte_idx,
  output logic                     overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int STOP_CYC     = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CYC);
  localparam int IDX_W        = $clog2(MSG_LEN) + 1;
  localparam int PER_W        = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MSG_LEN - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);

`ifdef UART_BURST_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [IDX_W-1:0]     byte_idx_reg, byte_idx_next;
  logic [8*MSG_LEN-1:0] shadow_reg, shadow_next;
  logic [PER_W-1:0]     interval_reg, interval_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 overrun_reg, overrun_next;

  logic                 interval_tc;
  logic                 trigger;
  logic                 busy_w;
  logic [7:0]           next_byte;

  // Interval timer: free-runs 0..PERIOD_CYC-1 only while auto_en is high.
  assign interval_tc = (interval_reg == PER_LAST);
  assign trigger     = go | (auto_en & interval_tc);
  assign busy_w      = (state_reg != IDLE);

  always_comb begin
    interval_next = '0;
    if (auto_en && !interval_tc) begin
      interval_next = interval_reg + 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    shadow_next   = shadow_reg;
    done_next     = 1'b0;
    overrun_next  = overrun_reg | (trigger & busy_w);
    tx_next       = 1'b1;
    next_byte     = '0;

    unique case (state_reg)
      IDLE: begin
        if (trigger) begin
          shadow_next   = msg;
          state_next    = START;
          cnt_next      = '0;
          byte_idx_next = '0;
        end
      end

      START: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_BURST_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

`ifdef UART_BURST_PARITY_EN
      PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif

      STOP: begin
        if (cnt_reg == STOP_LAST) begin
          cnt_next = '0;
          if (byte_idx_reg == IDX_LAST) begin
            state_next    = IDLE;
            byte_idx_next = '0;
            done_next     = 1'b1;
          end else begin
            // The shadow shifts down so the byte on the line is always bits [7:0].
            state_next    = START;
            byte_idx_next = byte_idx_reg + 1'b1;
            shadow_next   = shadow_reg >> 8;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // tx is registered, so it is computed from the state being entered.
    next_byte = shadow_next[7:0];
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = next_byte[bit_idx_next];
`ifdef UART_BURST_PARITY_EN
      PARITY:  tx_next = ^next_byte;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shadow_reg   <= '0;
      interval_reg <= '0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      shadow_reg   <= shadow_next;
      interval_reg <= interval_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign tx       = tx_reg;
  assign busy     = busy_w;
  assign done     = done_reg;
  assign byte_idx = byte_idx_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Bench for uart_burst_tx: two instances (1 and 2 stop bits) checked against a frame-list line model.
module tb_uart_burst_tx;
  localparam int CPB = 10;
`ifdef UART_BURST_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_A = CPB * (10 + PAR);
  localparam int FRAME_B = CPB * (11 + PAR);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go_a = 1'b0, auto_a = 1'b0, go_b = 1'b0;
  logic [15:0] msg_a = '0, msg_b = '0;
  logic        tx_a, busy_a, done_a, ovr_a;
  logic        tx_b, busy_b, done_b, ovr_b;
  logic [1:0]  idx_a, idx_b;

  always #5 clk = ~clk;

  uart_burst_tx #(.CLK_HZ(1000), .BAUD(100), .MSG_LEN(2), .PERIOD_CYC(500), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .auto_en(auto_a), .msg(msg_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .byte_idx(idx_a), .overrun(ovr_a));

  uart_burst_tx #(.CLK_HZ(1000), .BAUD(100), .MSG_LEN(2), .PERIOD_CYC(500), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .auto_en(1'b0), .msg(msg_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .byte_idx(idx_b), .overrun(ovr_b));

  int checks = 0;
  int fails  = 0;

  bit          use_b = 1'b0;
  logic        tx_s, busy_s, done_s;
  logic [1:0]  idx_s;
  assign tx_s   = use_b ? tx_b : tx_a;
  assign busy_s = use_b ? busy_b : busy_a;
  assign done_s = use_b ? done_b : done_a;
  assign idx_s  = use_b ? idx_b : idx_a;

  bit         exp_q[$];
  bit         act_q[$];
  int         busy_len, done_at, done_cnt;
  logic [1:0] idx0, idx1;
  logic       chain_busy, chain_tx;

  typedef struct {
    logic [15:0] msg;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line model: each byte is a list of bits, each bit stretched to CPB cycles.
  task automatic make_expected(input logic [15:0] m, input int stops);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      b = m[8*k +: 8];
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(b[i]);
      if (PAR != 0) repeat (CPB) exp_q.push_back(^b);
      repeat (stops * CPB) exp_q.push_back(1'b1);
    end
  endtask

  task automatic compare_wave(input string name);
    int first_bad;
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      if (first_bad < 0 && act_q[i] != exp_q[i]) first_bad = i;
    checks++;
    if (first_bad >= 0 || act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s: got %0d line bits (first diff at %0d), expected %0d bits matching",
               name, act_q.size(), first_bad, exp_q.size());
    end
  endtask

  // Mid-bit sampling receiver over the captured line.
  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    int j;
    for (int i = 0; i < 8; i++) begin
      j = base + CPB * (1 + i) + CPB / 2;
      d[i] = (j < act_q.size()) ? act_q[j] : 1'bx;
    end
    return d;
  endfunction

  task automatic run_burst(input bit sel, input logic [15:0] m, input bit scramble,
                           input bit chain, input int second_go);
    int frame;
    use_b = sel;
    frame = sel ? FRAME_B : FRAME_A;
    act_q.delete();
    busy_len = 0; done_at = -1; done_cnt = 0;
    chain_busy = 1'b0; chain_tx = 1'b1; idx0 = 2'bx; idx1 = 2'bx;
    @(negedge clk);
    if (sel) begin msg_b = m; go_b = 1'b1; end
    else begin msg_a = m; go_a = 1'b1; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      go_a = 1'b0; go_b = 1'b0;
      if (c == second_go) go_a = 1'b1;
      if (busy_s) begin act_q.push_back(tx_s); busy_len++; end
      if (c == 5) idx0 = idx_s;
      if (c == frame + 5) idx1 = idx_s;
      if (scramble && (c % 37) == 3) begin msg_a = 16'($urandom); msg_b = 16'($urandom); end
      if (done_s) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          if (chain) begin
            go_a = 1'b1;
            @(negedge clk);
            go_a = 1'b0;
            chain_busy = busy_a;
            chain_tx = tx_a;
            break;
          end
        end
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    $display("burst sel=%0d msg=%h busy_cycles=%0d done_at=%0d", sel, m, busy_len, done_at);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m;
    int          run, waited, p;
    logic        prev;
    int          starts[$];

    vecs[0] = '{16'h4241, 8'h41, 8'h42};
    vecs[1] = '{16'h00FF, 8'hFF, 8'h00};
    vecs[2] = '{16'h8001, 8'h01, 8'h80};
    vecs[3] = '{16'hA55A, 8'h5A, 8'hA5};

    repeat (3) @(negedge clk);
    check("reset_tx", tx_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_idx", idx_a, 0);
    check("reset_ovr", ovr_a, 0);
    check("reset_tx_b", tx_b, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[v]) begin
      run_burst(0, vecs[v].msg, 0, 0, -1);
      make_expected(vecs[v].msg, 1);
      compare_wave($sformatf("vec%0d_wave", v));
      check($sformatf("vec%0d_first_tx", v), act_q.size() > 0 ? act_q[0] : 1'bx, 0);
      check($sformatf("vec%0d_byte0", v), decode(0), vecs[v].b0);
      check($sformatf("vec%0d_byte1", v), decode(FRAME_A), vecs[v].b1);
      check($sformatf("vec%0d_busy_len", v), busy_len, 2 * FRAME_A);
      check($sformatf("vec%0d_done_at", v), done_at, 2 * FRAME_A);
      check($sformatf("vec%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("vec%0d_idx0", v), idx0, 0);
      check($sformatf("vec%0d_idx1", v), idx1, 1);
    end

`ifdef UART_BURST_PARITY_EN
    run_burst(0, 16'h0307, 0, 0, -1);
    check("parity_07", act_q.size() > 95 ? act_q[95] : 1'bx, 1);
    check("parity_03", act_q.size() > FRAME_A + 95 ? act_q[FRAME_A + 95] : 1'bx, 0);
`endif

    for (int r = 0; r < 5; r++) begin
      m = 16'($urandom);
      run_burst(0, m, 1, 0, -1);
      make_expected(m, 1);
      compare_wave($sformatf("rand%0d_wave", r));
      check($sformatf("rand%0d_done_cnt", r), done_cnt, 1);
    end

    // Trigger in the done cycle starts the next burst immediately.
    run_burst(0, 16'h4241, 0, 1, -1);
    check("chain_busy", chain_busy, 1);
    check("chain_tx", chain_tx, 0);
    waited = 0;
    while (!done_a && waited < 400) begin @(negedge clk); waited++; end
    check("chain_second_done", done_a, 1);
    check("chain_no_overrun", ovr_a, 0);

    run_burst(1, 16'h4241, 0, 0, -1);
    make_expected(16'h4241, 2);
    compare_wave("stop2_wave");
    check("stop2_busy_len", busy_len, 2 * FRAME_B);
    check("stop2_done_at", done_at, 2 * FRAME_B);
    run = 0;
    for (int j = CPB * (9 + PAR); j < act_q.size() && act_q[j]; j++) run++;
    check("stop2_gap", run, 20);
    use_b = 1'b0;

    run_burst(0, 16'h4241, 0, 0, 50);
    make_expected(16'h4241, 1);
    compare_wave("ovr_wave");
    check("ovr_busy_len", busy_len, 2 * FRAME_A);
    check("ovr_set", ovr_a, 1);
    waited = 0;
    repeat (30) begin @(negedge clk); if (busy_a) waited++; end
    check("ovr_no_second", waited, 0);

    // Reset in the middle of a burst.
    @(negedge clk); msg_a = 16'h4241; go_a = 1'b1;
    @(negedge clk); go_a = 1'b0;
    repeat (39) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_ovr", ovr_a, 0);
    check("midrst_idx", idx_a, 0);
    @(negedge clk); rst_n = 1'b1;
    run_burst(0, 16'h4241, 0, 0, -1);
    make_expected(16'h4241, 1);
    compare_wave("midrst_restart_wave");

    // Auto trigger timing from reset release.
    @(negedge clk); rst_n = 1'b0; auto_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev = 1'b0;
    for (p = 1; p <= 1700; p++) begin
      @(negedge clk);
      if (busy_a && !prev) starts.push_back(p);
      prev = busy_a;
    end
    auto_a = 1'b0;
    check("auto_count", starts.size(), 3);
    check("auto_start0", starts.size() > 0 ? starts[0] : -1, 500);
    check("auto_start1", starts.size() > 1 ? starts[1] : -1, 1000);
    check("auto_start2", starts.size() > 2 ? starts[2] : -1, 1500);
    check("auto_ovr", ovr_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
